// File: rtl/irq_pkg.sv
// Shared widths, FSM state encoding and a small decode helper for the
// interrupt request front-end.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    function automatic logic [N_IRQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = N_IRQ'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_capture.sv
// Request capture: previous-sample register, set-term generation and the
// sticky pending register where a new set beats a same-cycle clear.
module irq_capture
    import irq_pkg::*;
#(
    parameter int EDGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] clr,
    output logic [N_IRQ-1:0] pending
);

    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] w_set;

    // r_irq_q resets to 0, so a line held high through reset reads as a fresh edge
    always_comb begin
        w_set = (EDGE != 0) ? (irq & ~r_irq_q) : irq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_q   <= irq;
            r_pending <= (r_pending & ~clr) | w_set;
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request front-end: presents masked pending requests to a sibling
// priority encoder and runs the ack / end-of-interrupt handshake with the CPU.
//
//   state   | meaning
//   IDLE    | nothing unmasked pending, encoder disabled
//   REQ     | encoder enabled, int_o high, waiting for ack
//   SERVICE | request accepted, active_idx in service, waiting for eoi
module irq_request_ctrl
    import irq_pkg::*;
#(
    parameter int EDGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] mask,
    output logic             en,
    output logic [N_IRQ-1:0] req_vec,
    input  logic [IDX_W-1:0] idx,
    output logic             int_o,
    input  logic             ack,
    input  logic             eoi,
    output logic [IDX_W-1:0] active_idx,
    output logic             busy
);

    irq_state_t       r_state;
    irq_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_active_idx;
    logic [N_IRQ-1:0] w_pending;
    logic [N_IRQ-1:0] w_eff;
    logic [N_IRQ-1:0] w_clr;
    logic             w_accept;

    irq_capture #(
        .EDGE (EDGE)
    ) u_cap (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .clr     (w_clr),
        .pending (w_pending)
    );

    assign w_eff = w_pending & ~mask;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_eff) w_state_nxt = REQ;
            end
            REQ: begin
                // A withdrawn or freshly masked request cancels any same-cycle ack
                if (!(|w_eff)) begin
                    w_state_nxt = IDLE;
                end else if (ack) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clr = w_accept ? idx_onehot(idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_active_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_active_idx <= idx;
        end
    end

    assign en         = (r_state == REQ);
    assign req_vec    = en ? w_eff : '0;
    assign int_o      = en;
    assign busy       = (r_state == SERVICE);
    assign active_idx = r_active_idx;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Bench for irq_request_ctrl: an edge-mode and a level-mode instance, each fed
// by a behavioural highest-index-wins encoder, checked through a scoreboard.
module tb_irq_request_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // edge-mode instance
    logic       rst = 1'b1;
    logic [7:0] irq = '0, mask = '0;
    logic       ack = 1'b0, eoi = 1'b0;
    logic       en, int_o, busy;
    logic [7:0] req_vec;
    logic [2:0] idx, active_idx;

    // level-mode instance
    logic       rst_l = 1'b1;
    logic [7:0] irq_l = '0, mask_l = '0;
    logic       ack_l = 1'b0, eoi_l = 1'b0;
    logic       en_l, int_o_l, busy_l;
    logic [7:0] req_vec_l;
    logic [2:0] idx_l, active_idx_l;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic       en;
        logic [7:0] rv;
        logic       busy;
        logic [2:0] act;
        logic [7:0] pend;
    } exp_t;

    exp_t sb[$];

    function automatic logic [2:0] enc(input logic [7:0] v);
        enc = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) enc = 3'(i);
    endfunction

    always_comb idx   = enc(req_vec);
    always_comb idx_l = enc(req_vec_l);

    irq_request_ctrl #(.EDGE(1)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask(mask), .en(en),
        .req_vec(req_vec), .idx(idx), .int_o(int_o), .ack(ack), .eoi(eoi),
        .active_idx(active_idx), .busy(busy)
    );

    irq_request_ctrl #(.EDGE(0)) dut_l (
        .clk(clk), .rst(rst_l), .irq(irq_l), .mask(mask_l), .en(en_l),
        .req_vec(req_vec_l), .idx(idx_l), .int_o(int_o_l), .ack(ack_l), .eoi(eoi_l),
        .active_idx(active_idx_l), .busy(busy_l)
    );

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven; the expectation describes the state after the next edge.
    task automatic step(input string tag, input bit sel, input logic e_en, input logic [7:0] rv,
                        input logic e_busy, input logic [2:0] act, input logic [7:0] pend);
        exp_t e;
        e.tag = tag; e.sel = sel; e.en = e_en; e.rv = rv;
        e.busy = e_busy; e.act = act; e.pend = pend;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (!e.sel) begin
            chk_val({e.tag, ".en"},      8'(en),             8'(e.en));
            chk_val({e.tag, ".int_o"},   8'(int_o),          8'(e.en));
            chk_val({e.tag, ".req_vec"}, req_vec,            e.rv);
            chk_val({e.tag, ".busy"},    8'(busy),           8'(e.busy));
            chk_val({e.tag, ".active"},  8'(active_idx),     8'(e.act));
            chk_val({e.tag, ".pending"}, dut.w_pending,      e.pend);
        end else begin
            chk_val({e.tag, ".en"},      8'(en_l),           8'(e.en));
            chk_val({e.tag, ".int_o"},   8'(int_o_l),        8'(e.en));
            chk_val({e.tag, ".req_vec"}, req_vec_l,          e.rv);
            chk_val({e.tag, ".busy"},    8'(busy_l),         8'(e.busy));
            chk_val({e.tag, ".active"},  8'(active_idx_l),   8'(e.act));
            chk_val({e.tag, ".pending"}, dut_l.w_pending,    e.pend);
        end
    endtask

    initial begin
        // reset and quiet idle
        step("rst0", 0, 0, 8'h00, 0, 3'd0, 8'h00);
        step("rst1", 0, 0, 8'h00, 0, 3'd0, 8'h00);
        rst = 0;
        step("idle", 0, 0, 8'h00, 0, 3'd0, 8'h00);

        // 8'h24 pulse: pending after one edge, int_o after two, bit 5 served first
        irq = 8'h24;
        step("cap24", 0, 0, 8'h00, 0, 3'd0, 8'h24);
        irq = 8'h00;
        step("req24", 0, 1, 8'h24, 0, 3'd0, 8'h24);
        ack = 1;
        step("ack5", 0, 0, 8'h00, 1, 3'd5, 8'h04);
        step("ack_svc", 0, 0, 8'h00, 1, 3'd5, 8'h04);
        ack = 0; eoi = 1;
        step("eoi5", 0, 0, 8'h00, 0, 3'd5, 8'h04);
        eoi = 0;
        step("req04", 0, 1, 8'h04, 0, 3'd5, 8'h04);
        ack = 1;
        step("ack2", 0, 0, 8'h00, 1, 3'd2, 8'h00);
        ack = 0; eoi = 1;
        step("eoi2", 0, 0, 8'h00, 0, 3'd2, 8'h00);
        step("eoi_idle", 0, 0, 8'h00, 0, 3'd2, 8'h00);
        eoi = 0;

        // masked request stays pending, appears one edge after unmask
        mask = 8'h80; irq = 8'h80;
        step("mcap", 0, 0, 8'h00, 0, 3'd2, 8'h80);
        step("mhold", 0, 0, 8'h00, 0, 3'd2, 8'h80);
        mask = 8'h00;
        step("unmask", 0, 1, 8'h80, 0, 3'd2, 8'h80);
        ack = 1;
        step("ack7", 0, 0, 8'h00, 1, 3'd7, 8'h00);
        ack = 0; eoi = 1; irq = 8'h00;
        step("eoi7", 0, 0, 8'h00, 0, 3'd7, 8'h00);
        eoi = 0;

        // mask applied with ack in REQ: back to IDLE, nothing cleared
        irq = 8'h02;
        step("cap02", 0, 0, 8'h00, 0, 3'd7, 8'h02);
        irq = 8'h00;
        step("req02", 0, 1, 8'h02, 0, 3'd7, 8'h02);
        mask = 8'h02; ack = 1;
        step("mack", 0, 0, 8'h00, 0, 3'd7, 8'h02);
        ack = 0;

        // new edge on the bit being acknowledged keeps it pending
        irq = 8'h08;
        step("cap08", 0, 0, 8'h00, 0, 3'd7, 8'h0A);
        irq = 8'h00;
        step("req08", 0, 1, 8'h08, 0, 3'd7, 8'h0A);
        irq = 8'h08; ack = 1;
        step("setwin", 0, 0, 8'h00, 1, 3'd3, 8'h0A);
        ack = 0; eoi = 1;
        step("eoi3", 0, 0, 8'h00, 0, 3'd3, 8'h0A);
        eoi = 0;
        step("rereq08", 0, 1, 8'h08, 0, 3'd3, 8'h0A);

        // reset in SERVICE, line held high through reset gives one edge after release
        ack = 1;
        step("ack3b", 0, 0, 8'h00, 1, 3'd3, 8'h02);
        ack = 0; irq = 8'h11;
        step("cap11", 0, 0, 8'h00, 1, 3'd3, 8'h13);
        rst = 1;
        step("rst_svc", 0, 0, 8'h00, 0, 3'd0, 8'h00);
        step("rst_hold", 0, 0, 8'h00, 0, 3'd0, 8'h00);
        rst = 0;
        step("post_rst", 0, 0, 8'h00, 0, 3'd0, 8'h11);
        step("post_req", 0, 1, 8'h11, 0, 3'd0, 8'h11);

        // level mode: held line recaptured after reset, set beats clear on ack
        irq_l = 8'h01;
        step("l_rst", 1, 0, 8'h00, 0, 3'd0, 8'h00);
        rst_l = 0;
        step("l_cap", 1, 0, 8'h00, 0, 3'd0, 8'h01);
        step("l_req", 1, 1, 8'h01, 0, 3'd0, 8'h01);
        ack_l = 1;
        step("l_ack", 1, 0, 8'h00, 1, 3'd0, 8'h01);
        ack_l = 0; eoi_l = 1;
        step("l_eoi", 1, 0, 8'h00, 0, 3'd0, 8'h01);
        eoi_l = 0;
        step("l_rereq", 1, 1, 8'h01, 0, 3'd0, 8'h01);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_request_ctrl.md
# irq_request_ctrl

Interrupt request front-end that sits directly upstream of the 8-to-3 `priority_encoder`. It captures eight request lines into a sticky pending register and applies a mask. It drives the encoder's `en` and `i` inputs, and runs a request/acknowledge/end-of-interrupt handshake with the CPU side. On acknowledge it captures the encoder's `y` result as the in-service index and clears that pending bit.

## Interface
Parameters:
- `EDGE`, default 1: 1 = rising-edge-triggered capture; 0 = level-triggered capture.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq`  in  8  raw request lines, synchronous to `clk`.
- `mask`  in  8  1 = request line masked from presentation.
- `en`  out  1  drives encoder `en`.
- `req_vec`  out  8  drives encoder `i`.
- `idx`  in  3  encoder `y`; sampled only while `en`=1.
- `int_o`  out  1  interrupt request to CPU.
- `ack`  in  1  CPU acknowledge, one-cycle pulse.
- `eoi`  in  1  CPU end-of-interrupt, one-cycle pulse.
- `active_idx`  out  3  index currently in service.
- `busy`  out  1  1 while in state SERVICE.

## Operation
- Registers:
  - `irq_q[7:0]`: previous `irq`.
  - `pending[7:0]`.
  - `state`: IDLE, REQ or SERVICE.
  - `active_idx[2:0]`.
- Set term:
  - `set = irq & ~irq_q` when `EDGE`=1.
  - `set = irq` when `EDGE`=0.
- `pending` update:
  - Every edge: `pending <= (pending & ~clr) | set`.
  - `clr` is a one-hot of `idx`, active only on an accepted ack.
  - If `set` and `clr` hit the same bit, set wins (bit stays pending).
- `eff = pending & ~mask`. Masked bits remain pending and appear once unmasked.
- Combinational outputs:
  - `en` = (`state`==REQ).
  - `req_vec` = `en ? eff : 8'h00`.
  - `int_o` = `en`.
  - `busy` = (`state`==SERVICE).
- FSM:
  - IDLE: `|eff` → REQ; else stay.
  - REQ, `eff`==0 (masked or withdrawn): → IDLE. Any `ack` that cycle is ignored and no bit is cleared.
  - REQ, `ack`=1 and `eff`!=0: `active_idx <= idx`, clear `pending[idx]`, → SERVICE.
  - REQ, otherwise: stay.
  - SERVICE: `eoi`=1 → IDLE; else stay. New requests accumulate in `pending` meanwhile.
- Ignored inputs:
  - `ack` outside REQ is ignored.
  - `eoi` outside SERVICE is ignored.
- Reset values:
  - `irq_q`=0, `pending`=0, `state`=IDLE, `active_idx`=0.
  - Hence `en`=0, `req_vec`=0, `int_o`=0, `busy`=0.
- Reset mid-handshake (REQ or SERVICE) discards all pending and in-service state. Requests whose `irq` is still high at reset release are:
  - re-captured in level mode;
  - captured only on a new rising edge in edge mode, because `irq_q` resets to 0. A line held high through reset therefore yields one edge on the first post-reset cycle.

## Timing
- `irq` bit rising before edge t → `pending` set at edge t → `state`=REQ and `int_o`=1 after edge t+1. Request-to-interrupt latency is 2 edges.
- While `en`=1 the encoder `y` is valid combinationally; `idx` is sampled on the same edge as `ack`.
- `ack` at edge a → `busy`=1 and `int_o`=0 after edge a; `pending[idx]` is cleared at edge a.
- `eoi` at edge e → IDLE after e. If `eff`!=0, `int_o` reasserts after edge e+1, so there is a minimum one-cycle `int_o` gap between services.
- Back-to-back edges on one line while it is pending merge into a single request.

## Structure
- Package `irq_pkg`:
  - `N_IRQ`=8, `IDX_W`=3.
  - State enum `irq_state_t` {IDLE, REQ, SERVICE}.
- Sub-module `irq_capture`: holds `irq_q`, the `set` generation and `pending` with set/clear priority, parameterised by `EDGE`. The FSM and handshake stay in the top level.
- The top level instantiates `priority_encoder` only in the testbench; in the design the encoder is a sibling instance.

## Test plan
- Reset, then `irq`=8'h00 → all outputs 0; `irq`=8'h24 pulse → `int_o`=1 two edges later, `req_vec`=8'h24, encoder `idx`=5; `ack` → `active_idx`=5, `pending`=8'h04, `busy`=1.
- Continue the previous case: `eoi` → IDLE, `int_o` reasserts one edge later with `req_vec`=8'h04; `ack` → `active_idx`=2; `eoi` → `pending`=0, `int_o` stays 0.
- `mask`=8'h80, `irq[7]` rises → `int_o` stays 0, `pending`=8'h80; clear `mask` → `int_o`=1 after 1 edge, `active_idx`=7 on `ack`.
- In REQ with `eff`=8'h02, set `mask`=8'h02 in the same cycle as `ack` → return to IDLE, `pending` stays 8'h02, `active_idx` unchanged.
- `irq[3]` new rising edge on the same edge as `ack` with `idx`=3 → `pending[3]` stays 1; after `eoi`, `int_o` reasserts with `req_vec`=8'h08.
- Assert `rst` in SERVICE with `pending`=8'h11 → next edge all outputs 0. With `EDGE`=0 and `irq`=8'h01 held, `int_o` rises 2 edges after `rst` deasserts.
